// File: rtl/lifo_stack_ctrl.sv
// lifo_stack_ctrl: push/pop stack datapath with registered pop output and status/error pulses
module lifo_stack_ctrl #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] top_idx, wr_idx;
  logic             wr_en, rd_en;
  assign full    = count == PTR_W'(DEPTH);
  assign empty   = count == '0;
  assign top_idx = count - PTR_W'(1);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (pop || !full);
  assign wr_idx  = rd_en ? top_idx : count;
  assign top     = empty ? '0 : mem[top_idx[AW-1:0]];
  // storage is deliberately unreset; only pushed words can ever be read back
  always_ff @(posedge clk)
    if (!reset && wr_en) mem[wr_idx[AW-1:0]] <= data_in;
  // pointer, popped word and one-cycle strobes; a replace keeps count and never overflows
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count     <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= rd_en;
      overflow  <= push && !pop && full;
      underflow <= pop && empty;
      if (rd_en) data_out <= mem[top_idx[AW-1:0]];
      if (wr_en && !rd_en) count <= count + PTR_W'(1);
      else if (rd_en && !push) count <= top_idx;
    end
endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// tb_lifo_stack_ctrl: directed self-checking bench for lifo_stack_ctrl
module tb_lifo_stack_ctrl;
  logic       clk = 0, reset = 0, push = 0, pop = 0;
  logic [3:0] data_in = 0, data_out, top;
  logic [2:0] count;
  logic       out_valid, full, empty, overflow, underflow;
  int total = 0, bad = 0;

  lifo_stack_ctrl #(.DEPTH(4), .WIDTH(4), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
    .data_out(data_out), .out_valid(out_valid), .top(top), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic pu, input logic po, input logic [3:0] d);
    push = pu; pop = po; data_in = d;
    @(posedge clk); #1;
    push = 0; pop = 0;
  endtask

  initial begin
    #3 reset = 1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_top", top, 0);
    @(negedge clk); reset = 0;
    step(1, 0, 4'h1); chk("fill1_count", count, 1); chk("fill1_top", top, 4'h1);
    step(1, 0, 4'h2); chk("fill2_count", count, 2);
    step(1, 0, 4'h3); chk("fill3_count", count, 3); chk("fill3_full", full, 0);
    step(1, 0, 4'h4); chk("fill4_count", count, 4); chk("fill4_full", full, 1); chk("fill4_top", top, 4'h4);
    step(1, 0, 4'h5); chk("ovf_pulse", overflow, 1); chk("ovf_count", count, 4); chk("ovf_top", top, 4'h4);
    chk("ovf_uflow", underflow, 0);
    step(0, 0, 4'h0); chk("ovf_clear", overflow, 0);
    step(0, 1, 4'h0); chk("pop1_dout", data_out, 4'h4); chk("pop1_valid", out_valid, 1); chk("pop1_count", count, 3);
    step(0, 0, 4'h0); chk("pop1_valid_clr", out_valid, 0);
    step(0, 1, 4'h0); chk("pop2_dout", data_out, 4'h3); chk("pop2_count", count, 2);
    step(0, 1, 4'h0); chk("pop3_dout", data_out, 4'h2); chk("pop3_count", count, 1);
    step(0, 1, 4'h0); chk("pop4_dout", data_out, 4'h1); chk("pop4_count", count, 0); chk("pop4_empty", empty, 1);
    chk("pop4_top", top, 0);
    step(0, 1, 4'h0); chk("udf_pulse", underflow, 1); chk("udf_valid", out_valid, 0); chk("udf_dout", data_out, 4'h1);
    chk("udf_count", count, 0);
    step(1, 0, 4'hA); step(1, 0, 4'hB);
    step(1, 1, 4'hC); chk("rep_dout", data_out, 4'hB); chk("rep_valid", out_valid, 1); chk("rep_count", count, 2);
    chk("rep_top", top, 4'hC); chk("rep_ovf", overflow, 0); chk("rep_udf", underflow, 0);
    step(0, 1, 4'h0); chk("rep_pop_dout", data_out, 4'hC); chk("rep_pop_count", count, 1); chk("rep_pop_top", top, 4'hA);
    step(0, 1, 4'h0); chk("rep_pop2_dout", data_out, 4'hA); chk("rep_pop2_count", count, 0);
    step(1, 1, 4'h7); chk("pp_empty_count", count, 1); chk("pp_empty_top", top, 4'h7);
    chk("pp_empty_udf", underflow, 1); chk("pp_empty_valid", out_valid, 0);
    step(0, 1, 4'h0); chk("pp_pop_dout", data_out, 4'h7); chk("pp_pop_count", count, 0);
    step(1, 0, 4'h1); step(1, 0, 4'h2); step(1, 0, 4'h3); chk("midrst_pre", count, 3);
    #2 reset = 1;
    #1;
    chk("midrst_count", count, 0); chk("midrst_empty", empty, 1); chk("midrst_top", top, 0);
    @(negedge clk); reset = 0;
    step(1, 0, 4'h9); chk("post_push_count", count, 1); chk("post_push_top", top, 4'h9);
    step(0, 1, 4'h0); chk("post_pop_dout", data_out, 4'h9); chk("post_pop_count", count, 0);
    chk("post_pop_valid", out_valid, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
